rsm_controller: RTL and testbench

- Sequencing FSM that drives the register-file, datapath and instruction-field-select side of the Simple RISC Machine datapath.
- Consumes the decoded `opcode`/`op` fields of the current instruction and issues `nsel`, load strobes, operand selects and write-back controls, one micro-step per clock.
- It is the initiator of the `nsel` handshake that the instruction decoder answers with `readnum`/`writenum`.
- Sits between the instruction register/decoder and the datapath; `w` tells the top level when a new instruction may be started.

---
 rtl/rsm_pkg.sv | 25 ++
 rtl/rsm_controller.sv | 64 ++++++
 tb/tb_rsm_controller.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/rsm_pkg.sv
// rsm_pkg: shared state encoding, instruction field constants and decode helper for the RSM controller
package rsm_pkg;
  typedef enum logic [2:0] {WAIT, DECODE, GET_A, GET_B, ALU, WRITE_REG, WRITE_IMM} state_t;
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RM = 3'b001;
  localparam logic [2:0] NSEL_RD = 3'b010;
  localparam logic [2:0] NSEL_RN = 3'b100;
  localparam logic [1:0] VSEL_C = 2'b00;
  localparam logic [1:0] VSEL_PC = 2'b01;
  localparam logic [1:0] VSEL_IMM8 = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;
  function automatic state_t decode_next(input logic [2:0] opc, input logic [1:0] o);
    return {opc, o} == {OPC_MOV, OP_MOVI} ? WRITE_IMM :
           ({opc, o} == {OPC_MOV, OP_MOVR} || {opc, o} == {OPC_ALU, OP_MVN}) ? GET_B :
           opc == OPC_ALU ? GET_A : WAIT;
  endfunction
endpackage

// File: rtl/rsm_controller.sv
// rsm_controller: SRM sequencing FSM; in clk/reset_n/s/opcode/op, out nsel/vsel/asel/bsel/loada/loadb/loadc/loads/write/w/illegal
module rsm_controller
  import rsm_pkg::*;
#(
  parameter bit ILLEGAL_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       asel,
  output logic       bsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       write,
  output logic       w,
  output logic       illegal
);
  state_t state, next;
  logic is_cmp, is_unary, bad;
  assign is_cmp = {opcode, op} == {OPC_ALU, OP_CMP};
  assign is_unary = {opcode, op} == {OPC_MOV, OP_MOVR} || {opcode, op} == {OPC_ALU, OP_MVN};
  assign bad = decode_next(opcode, op) == WAIT;
  always_comb begin
    next = state;
    case (state)
      WAIT:    next = s ? DECODE : WAIT;
      DECODE:  next = decode_next(opcode, op);
      GET_A:   next = GET_B;
      GET_B:   next = ALU;
      ALU:     next = is_cmp ? WAIT : WRITE_REG;
      default: next = WAIT;
    endcase
  end
  always_comb begin
    nsel = (state == GET_A || state == WRITE_IMM) ? NSEL_RN :
           state == GET_B ? NSEL_RM :
           state == WRITE_REG ? NSEL_RD : NSEL_NONE;
    vsel = state == WRITE_IMM ? VSEL_IMM8 : VSEL_C;
    asel = state == ALU && is_unary;
    bsel = 1'b0;
    loada = state == GET_A;
    loadb = state == GET_B;
    loadc = state == ALU && !is_cmp;
    loads = state == ALU && is_cmp;
    write = state == WRITE_REG || state == WRITE_IMM;
    w = state == WAIT;
  end
  // sticky mode holds the flag until the next accepted start; pulse mode lets it drop after one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= WAIT;
      illegal <= 1'b0;
    end else begin
      state <= next;
      illegal <= (state == DECODE && bad) | (ILLEGAL_STICKY && illegal && !(state == WAIT && s));
    end
  end
endmodule

// File: tb/tb_rsm_controller.sv
// tb_rsm_controller: scoreboard bench for rsm_controller sequencing, latency, reset abort and illegal flag
module tb_rsm_controller;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic s = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic [1:0] op = 2'b00;
  logic [2:0] nsel;
  logic [1:0] vsel;
  logic asel, bsel, loada, loadb, loadc, loads, write, w, illegal;
  logic [13:0] obs, exp_v;
  logic [13:0] sb[$];
  int checks = 0;
  int errors = 0;
  localparam logic [13:0] IDLE0 = {3'b000, 2'b00, 1'b0, 1'b0, 5'b00000, 1'b1, 1'b0};
  localparam logic [13:0] IDLE1 = {3'b000, 2'b00, 1'b0, 1'b0, 5'b00000, 1'b1, 1'b1};
  localparam logic [13:0] DEC = {3'b000, 2'b00, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0};
  localparam logic [13:0] GA = {3'b100, 2'b00, 1'b0, 1'b0, 5'b10000, 1'b0, 1'b0};
  localparam logic [13:0] GB = {3'b001, 2'b00, 1'b0, 1'b0, 5'b01000, 1'b0, 1'b0};
  localparam logic [13:0] ALU_BIN = {3'b000, 2'b00, 1'b0, 1'b0, 5'b00100, 1'b0, 1'b0};
  localparam logic [13:0] ALU_UN = {3'b000, 2'b00, 1'b1, 1'b0, 5'b00100, 1'b0, 1'b0};
  localparam logic [13:0] ALU_CMP = {3'b000, 2'b00, 1'b0, 1'b0, 5'b00010, 1'b0, 1'b0};
  localparam logic [13:0] WREG = {3'b010, 2'b00, 1'b0, 1'b0, 5'b00001, 1'b0, 1'b0};
  localparam logic [13:0] WIMM = {3'b100, 2'b10, 1'b0, 1'b0, 5'b00001, 1'b0, 1'b0};
  assign obs = {nsel, vsel, asel, bsel, loada, loadb, loadc, loads, write, w, illegal};
  always #5 clk = ~clk;
  rsm_controller #(.ILLEGAL_STICKY(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .s(s), .opcode(opcode), .op(op),
    .nsel(nsel), .vsel(vsel), .asel(asel), .bsel(bsel),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .write(write), .w(w), .illegal(illegal)
  );
  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== IDLE0) begin errors++; $display("FAIL reset_init got %b want %b", obs, IDLE0); end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    opcode = 3'b101; op = 2'b00; s = 1'b1;
    sb.push_back(DEC); sb.push_back(GA); sb.push_back(GB);
    for (int i = 0; sb.size() > 0; i++) begin
      @(posedge clk);
      #1 s = 1'b0;
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL reset_pre step %0d got %b want %b", i, obs, exp_v); end
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== IDLE0) begin errors++; $display("FAIL reset_async got %b want %b", obs, IDLE0); end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (obs !== IDLE0) begin errors++; $display("FAIL reset_hold cycle %0d got %b want %b", i, obs, IDLE0); end
    end
    reset_n = 1'b1;
  endtask
  task automatic test_movi();
    opcode = 3'b110; op = 2'b10; s = 1'b1;
    sb.push_back(DEC); sb.push_back(WIMM); sb.push_back(IDLE0); sb.push_back(IDLE0);
    for (int i = 0; sb.size() > 0; i++) begin
      @(posedge clk);
      #1 s = 1'b0;
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL movi step %0d got %b want %b", i, obs, exp_v); end
    end
  endtask
  task automatic test_binop(input logic [1:0] o);
    opcode = 3'b101; op = o; s = 1'b1;
    sb.push_back(DEC); sb.push_back(GA); sb.push_back(GB); sb.push_back(ALU_BIN);
    sb.push_back(WREG); sb.push_back(IDLE0); sb.push_back(IDLE0);
    for (int i = 0; sb.size() > 0; i++) begin
      @(posedge clk);
      #1 s = 1'b0;
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL binop_%0d step %0d got %b want %b", o, i, obs, exp_v); end
    end
  endtask
  task automatic test_cmp();
    opcode = 3'b101; op = 2'b01; s = 1'b1;
    sb.push_back(DEC); sb.push_back(GA); sb.push_back(GB); sb.push_back(ALU_CMP);
    sb.push_back(IDLE0); sb.push_back(IDLE0);
    for (int i = 0; sb.size() > 0; i++) begin
      @(posedge clk);
      #1 s = 1'b0;
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL cmp step %0d got %b want %b", i, obs, exp_v); end
    end
  endtask
  task automatic test_back_to_back();
    opcode = 3'b101; op = 2'b11; s = 1'b1;
    sb.push_back(DEC); sb.push_back(GB); sb.push_back(ALU_UN); sb.push_back(WREG); sb.push_back(IDLE0);
    sb.push_back(DEC); sb.push_back(GB); sb.push_back(ALU_UN); sb.push_back(WREG); sb.push_back(IDLE0);
    sb.push_back(IDLE0);
    for (int i = 0; sb.size() > 0; i++) begin
      @(posedge clk);
      #1;
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL b2b step %0d got %b want %b", i, obs, exp_v); end
      if (i == 4) begin opcode = 3'b110; op = 2'b00; end
      if (i == 5) s = 1'b0;
    end
  endtask
  task automatic test_illegal(input logic [2:0] opc, input logic [1:0] o);
    opcode = opc; op = o; s = 1'b1;
    sb.push_back(DEC); sb.push_back(IDLE1); sb.push_back(IDLE1); sb.push_back(IDLE1);
    for (int i = 0; sb.size() > 0; i++) begin
      @(posedge clk);
      #1 s = 1'b0;
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL illegal_%b_%b step %0d got %b want %b", opc, o, i, obs, exp_v); end
    end
    opcode = 3'b110; op = 2'b10; s = 1'b1;
    sb.push_back(DEC); sb.push_back(WIMM); sb.push_back(IDLE0);
    for (int i = 0; sb.size() > 0; i++) begin
      @(posedge clk);
      #1 s = 1'b0;
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL illegal_clear step %0d got %b want %b", i, obs, exp_v); end
    end
  endtask
  initial begin
    test_reset();
    test_movi();
    test_binop(2'b00);
    test_binop(2'b10);
    test_cmp();
    test_back_to_back();
    test_illegal(3'b111, 2'b00);
    test_illegal(3'b110, 2'b01);
    test_illegal(3'b000, 2'b11);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
